dispatch_router: RTL and testbench
==================================

# dispatch_router

Parametrised successor to the fixed four-unit instruction router. It sits between rename/dispatch and the N functional-unit queues, and owns three jobs:
- steers each renamed instruction into a per-FU staging FIFO under a valid/ready handshake;
- snoops writeback so buffered operands never miss a wakeup;
- re-broadcasts all writeback PRNs to every FU queue as a registered wakeup bus.

## Interface
Parameters:
- INST_ID_BITS, 6, instruction ID width
- PRN_BITS, 6, physical register number width
- MAX_OPERANDS, 3, source/destination operand slots per instruction
- FU_COUNT, 4, number of functional units (2..16)
- FUC_BITS, 2, FU choice width; must satisfy 2**FUC_BITS >= FU_COUNT
- BUF_DEPTH, 2, staging FIFO entries per FU; power of two, >= 2

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  dispatch offers an instruction
- in_ready  out  1  router accepts the instruction this cycle
- in_inst_id  in  INST_ID_BITS  instruction ID
- in_raw_instr  in  32  instruction encoding
- in_pc  in  64  instruction PC
- in_fu_choice  in  FUC_BITS  target FU
- in_src_valid / in_src_ready  in  [MAX_OPERANDS] x 1  source operand used / already ready
- in_src_prn  in  [MAX_OPERANDS] x PRN_BITS  source PRNs
- in_dst_valid  in  [MAX_OPERANDS] x 1  destination used
- in_dst_prn  in  [MAX_OPERANDS] x PRN_BITS  destination PRNs
- fu_valid  out  [FU_COUNT] x 1  head of FU i's FIFO offered to FU queue i
- fu_ready  in  [FU_COUNT] x 1  FU queue i has space
- fu_* payload  out  [FU_COUNT] x (same fields as in_*)  head entry of FU i's FIFO
- wb_en  in  [FU_COUNT][MAX_OPERANDS] x 1  FU writes a PRN this cycle
- wb_prn  in  [FU_COUNT][MAX_OPERANDS] x PRN_BITS  PRN being written
- wake_en  out  [FU_COUNT][MAX_OPERANDS] x 1  registered copy of wb_en
- wake_prn  out  [FU_COUNT][MAX_OPERANDS] x PRN_BITS  registered copy of wb_prn
- fu_occupancy  out  [FU_COUNT] x clog2(BUF_DEPTH+1)  entries held per FU
- err_bad_fu  out  1  one-cycle pulse: an instruction with in_fu_choice >= FU_COUNT was dropped

## Operation
- **Accept.** `in_ready = (in_fu_choice >= FU_COUNT) || (fu_occupancy[in_fu_choice] < BUF_DEPTH)`.
  - in_ready depends only on registered state and in_fu_choice. It has no path from fu_ready.
- **Enqueue.** On in_valid && in_ready with a legal choice, the payload is written at the tail of the chosen FIFO.
- **Bad FU.** On in_valid with in_fu_choice >= FU_COUNT, the instruction is consumed and discarded. err_bad_fu = 1 on the next cycle. No FIFO changes.
- **Dequeue.** `fu_valid[i] = fu_occupancy[i] != 0`. On fu_valid[i] && fu_ready[i], the head pops. FIFOs are independent of one another.
- **Wakeup snoop** (per operand j, per entry or incoming instruction). The source-ready bit becomes 1 when src_valid[j] is set and any wb_en[f][k] is set with wb_prn[f][k] == src_prn[j].
  - Applies to stored entries every cycle.
  - Applies to the incoming payload as it is written.
  - Applies combinationally to the fu_* output of the head, so a wakeup arriving in the pop cycle is not lost.
  - Ready bits are sticky until the entry pops.
  - Operands with src_valid = 0 are never set ready.
- **Broadcast.** wake_en/wake_prn are a one-stage register of wb_en/wb_prn, fanned out to all FU queues, the issuing FU included. A duplicate wakeup of an operand that is already ready is legal and harmless.
- **Pointers.** Head/tail pointers are clog2(BUF_DEPTH) bits and wrap modulo BUF_DEPTH. Occupancy is tracked separately, so full and empty are unambiguous.
- **Push and pop together.** A push and a pop on the same FIFO in the same cycle leave occupancy unchanged.
- **Full with pop.** When the FIFO is full and a pop occurs, in_ready is still 0 that cycle (no same-cycle pass-through).

## Timing
- **Reset.** While rst = 0, asynchronously:
  - all FIFOs empty, fu_occupancy = 0, fu_valid = 0;
  - wake_en = 0, wake_prn = 0, err_bad_fu = 0;
  - fu_* payloads driven to 0 when the FIFO is empty.
  - Reset asserted mid-operation discards all buffered instructions. No partial state survives.
- **Dispatch latency.** An accepted instruction appears on fu_valid at the cycle after acceptance (1 cycle).
- **Throughput.** Full throughput is 1 instruction per cycle per FU while fu_ready = 1.
- **Wakeup latency.** A wb event in cycle t:
  - is visible on wake_en at t+1;
  - marks matching buffered operands in cycle t itself (combinationally at the head, stored at the t/t+1 edge).
- **err_bad_fu.** Registered; high for exactly one cycle per dropped instruction.

## Test plan
- **Reset/basic dispatch.** Release reset; offer id 5 to FU 2 with fu_ready[2] = 1. Required:
  - before acceptance, every output is 0 and in_ready = 1;
  - fu_valid[2] = 1 with id 5 one cycle after acceptance;
  - fu_occupancy[2] returns to 0 after the pop.
- **Backpressure/full.** Hold fu_ready[1] = 0 and send 3 instructions to FU 1 (BUF_DEPTH = 2). Required:
  - in_ready = 0 on the 3rd;
  - release fu_ready[1]: ids pop in order, and the 3rd is accepted on the cycle after the first pop.
- **Wakeup snoop.** Buffer an instruction with src PRN 17 not ready (fu_ready = 0). Pulse wb_en[3][0] with wb_prn = 17. Required:
  - src_ready = 1 on the popped entry;
  - wake_en[3][0] = 1 with wake_prn 17 one cycle after the pulse.
- **Same-cycle wakeup.** Pulse wb PRN 9 in the same cycle an instruction with src PRN 9 is enqueued, and separately in the same cycle a head with src PRN 9 pops. Required: src_ready = 1 in both cases.
- **Bad FU.** With FU_COUNT = 3, offer fu_choice 3. Required: in_ready = 1, err_bad_fu = 1 for exactly one cycle, no fu_valid.
- **Reset mid-operation.** Fill all FIFOs, then assert rst for 1 cycle. Required: all occupancies are 0 and no stale instruction appears afterward.

Source files
------------

// File: rtl/dispatch_router.sv
// dispatch_router: steers renamed instructions into per-FU staging FIFOs,
// snoops writeback into buffered source-ready bits, re-broadcasts wakeups.
//
// Ports:
//   clk, rst            clock, async active-low reset
//   in_*                dispatch side, valid/ready handshake
//   fu_*                per-FU head entry, valid/ready handshake
//   wb_en, wb_prn       writeback PRNs from every FU this cycle
//   wake_en, wake_prn   one-cycle registered copy of wb_en/wb_prn
//   fu_occupancy        entries held per FU FIFO
//   err_bad_fu          pulse after an out-of-range FU choice was dropped
module dispatch_router #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int FU_COUNT     = 4,
  parameter int FUC_BITS     = 2,
  parameter int BUF_DEPTH    = 2
) (
  input  logic clk,
  input  logic rst,

  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [INST_ID_BITS-1:0]   in_inst_id,
  input  logic [31:0]               in_raw_instr,
  input  logic [63:0]               in_pc,
  input  logic [FUC_BITS-1:0]       in_fu_choice,
  input  logic [MAX_OPERANDS-1:0]   in_src_valid,
  input  logic [MAX_OPERANDS-1:0]   in_src_ready,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] in_src_prn,
  input  logic [MAX_OPERANDS-1:0]   in_dst_valid,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] in_dst_prn,

  output logic [FU_COUNT-1:0]       fu_valid,
  input  logic [FU_COUNT-1:0]       fu_ready,
  output logic [FU_COUNT-1:0][INST_ID_BITS-1:0] fu_inst_id,
  output logic [FU_COUNT-1:0][31:0] fu_raw_instr,
  output logic [FU_COUNT-1:0][63:0] fu_pc,
  output logic [FU_COUNT-1:0][FUC_BITS-1:0] fu_fu_choice,
  output logic [FU_COUNT-1:0][MAX_OPERANDS-1:0] fu_src_valid,
  output logic [FU_COUNT-1:0][MAX_OPERANDS-1:0] fu_src_ready,
  output logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] fu_src_prn,
  output logic [FU_COUNT-1:0][MAX_OPERANDS-1:0] fu_dst_valid,
  output logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] fu_dst_prn,

  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0] wb_en,
  input  logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] wb_prn,
  output logic [FU_COUNT-1:0][MAX_OPERANDS-1:0] wake_en,
  output logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] wake_prn,

  output logic [FU_COUNT-1:0][$clog2(BUF_DEPTH+1)-1:0] fu_occupancy,
  output logic                      err_bad_fu
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int OCC_W = $clog2(BUF_DEPTH+1);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(BUF_DEPTH);
  localparam logic [FUC_BITS:0] NFU = (FUC_BITS+1)'(FU_COUNT);

  typedef logic [MAX_OPERANDS-1:0] opv_t;
  typedef logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] opp_t;
  typedef logic [FU_COUNT-1:0][MAX_OPERANDS-1:0] wbe_t;
  typedef logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0] wbp_t;

  typedef struct packed {
    logic [INST_ID_BITS-1:0] inst_id;
    logic [31:0]             raw_instr;
    logic [63:0]             pc;
    logic [FUC_BITS-1:0]     fu_choice;
    opv_t                    src_valid;
    opv_t                    src_ready;
    opp_t                    src_prn;
    opv_t                    dst_valid;
    opp_t                    dst_prn;
  } entry_t;

  // Sticky ready merge: a used operand whose PRN matches any writeback.
  function automatic opv_t snoop(
    input opv_t sv,
    input opv_t sr,
    input opp_t sp,
    input wbe_t we,
    input wbp_t wp
  );
    opv_t r;
    r = sr;
    for (int j = 0; j < MAX_OPERANDS; j++)
      for (int f = 0; f < FU_COUNT; f++)
        for (int k = 0; k < MAX_OPERANDS; k++)
          if (sv[j] && we[f][k] && wp[f][k] == sp[j])
            r[j] = 1'b1;
    return r;
  endfunction

  entry_t             mem_q [FU_COUNT][BUF_DEPTH];
  entry_t             mem_d [FU_COUNT][BUF_DEPTH];
  logic [PTR_W-1:0]   head_q [FU_COUNT];
  logic [PTR_W-1:0]   head_d [FU_COUNT];
  logic [PTR_W-1:0]   tail_q [FU_COUNT];
  logic [PTR_W-1:0]   tail_d [FU_COUNT];
  logic [OCC_W-1:0]   occ_q  [FU_COUNT];
  logic [OCC_W-1:0]   occ_d  [FU_COUNT];
  logic [FU_COUNT-1:0] push;
  logic [FU_COUNT-1:0] pop;
  logic               choice_ok;
  logic               err_q;
  logic               err_d;
  wbe_t               wake_en_q;
  wbp_t               wake_prn_q;
  entry_t             in_ent;
  entry_t             head_ent [FU_COUNT];

  always_comb begin : accept
    choice_ok = {1'b0, in_fu_choice} < NFU;
    // Out-of-range choices are always drained.
    in_ready  = 1'b1;
    push      = '0;
    pop       = '0;
    for (int i = 0; i < FU_COUNT; i++) begin
      if (in_fu_choice == FUC_BITS'(i))
        in_ready = (occ_q[i] != FULL);
      push[i] = in_valid && (in_fu_choice == FUC_BITS'(i))
                && (occ_q[i] != FULL);
      pop[i]  = (occ_q[i] != '0) && fu_ready[i];
    end
    err_d = in_valid && !choice_ok;
  end

  always_comb begin : incoming
    in_ent           = '0;
    in_ent.inst_id   = in_inst_id;
    in_ent.raw_instr = in_raw_instr;
    in_ent.pc        = in_pc;
    in_ent.fu_choice = in_fu_choice;
    in_ent.src_valid = in_src_valid;
    in_ent.src_ready = snoop(in_src_valid, in_src_ready, in_src_prn,
                             wb_en, wb_prn);
    in_ent.src_prn   = in_src_prn;
    in_ent.dst_valid = in_dst_valid;
    in_ent.dst_prn   = in_dst_prn;
  end

  always_comb begin : next_state
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    for (int i = 0; i < FU_COUNT; i++) begin
      for (int e = 0; e < BUF_DEPTH; e++)
        mem_d[i][e].src_ready = snoop(mem_q[i][e].src_valid,
                                      mem_q[i][e].src_ready,
                                      mem_q[i][e].src_prn,
                                      wb_en, wb_prn);
      if (push[i]) begin
        mem_d[i][tail_q[i]] = in_ent;
        tail_d[i] = tail_q[i] + PTR_W'(1);
      end
      if (pop[i])
        head_d[i] = head_q[i] + PTR_W'(1);
      case ({push[i], pop[i]})
        2'b10:   occ_d[i] = occ_q[i] + OCC_W'(1);
        2'b01:   occ_d[i] = occ_q[i] - OCC_W'(1);
        default: occ_d[i] = occ_q[i];
      endcase
    end
  end

  // Head view also sees this cycle's writeback so a pop never loses it.
  always_comb begin : heads
    for (int i = 0; i < FU_COUNT; i++) begin
      fu_valid[i]     = (occ_q[i] != '0);
      fu_occupancy[i] = occ_q[i];
      head_ent[i]     = '0;
      if (fu_valid[i]) begin
        head_ent[i] = mem_q[i][head_q[i]];
        head_ent[i].src_ready = snoop(head_ent[i].src_valid,
                                      head_ent[i].src_ready,
                                      head_ent[i].src_prn,
                                      wb_en, wb_prn);
      end
      fu_inst_id[i]   = head_ent[i].inst_id;
      fu_raw_instr[i] = head_ent[i].raw_instr;
      fu_pc[i]        = head_ent[i].pc;
      fu_fu_choice[i] = head_ent[i].fu_choice;
      fu_src_valid[i] = head_ent[i].src_valid;
      fu_src_ready[i] = head_ent[i].src_ready;
      fu_src_prn[i]   = head_ent[i].src_prn;
      fu_dst_valid[i] = head_ent[i].dst_valid;
      fu_dst_prn[i]   = head_ent[i].dst_prn;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FU_COUNT; i++) begin
        head_q[i] <= '0;
        tail_q[i] <= '0;
        occ_q[i]  <= '0;
      end
      wake_en_q  <= '0;
      wake_prn_q <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < FU_COUNT; i++) begin
        head_q[i] <= head_d[i];
        tail_q[i] <= tail_d[i];
        occ_q[i]  <= occ_d[i];
      end
      wake_en_q  <= wb_en;
      wake_prn_q <= wb_prn;
      err_q      <= err_d;
    end
  end

  // Payload storage needs no reset: outputs are gated by occupancy.
  always_ff @(posedge clk) begin
    for (int i = 0; i < FU_COUNT; i++)
      for (int e = 0; e < BUF_DEPTH; e++)
        mem_q[i][e] <= mem_d[i][e];
  end

  assign wake_en    = wake_en_q;
  assign wake_prn   = wake_prn_q;
  assign err_bad_fu = err_q;

endmodule

// File: tb/tb_dispatch_router.sv
// tb_dispatch_router: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_dispatch_router;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic             in_valid, in_ready;
  logic [5:0]       in_inst_id;
  logic [31:0]      in_raw_instr;
  logic [63:0]      in_pc;
  logic [1:0]       in_fu_choice;
  logic [2:0]       in_src_valid, in_src_ready, in_dst_valid;
  logic [2:0][5:0]  in_src_prn, in_dst_prn;

  logic [3:0]       fu_valid, fu_ready;
  logic [3:0][5:0]  fu_inst_id;
  logic [3:0][31:0] fu_raw_instr;
  logic [3:0][63:0] fu_pc;
  logic [3:0][1:0]  fu_fu_choice;
  logic [3:0][2:0]  fu_src_valid, fu_src_ready, fu_dst_valid;
  logic [3:0][2:0][5:0] fu_src_prn, fu_dst_prn;
  logic [3:0][2:0]  wb_en, wake_en;
  logic [3:0][2:0][5:0] wb_prn, wake_prn;
  logic [3:0][1:0]  fu_occupancy;
  logic             err_bad_fu;

  // Second instance with FU_COUNT = 3 for the out-of-range choice.
  logic             in_valid3, in_ready3;
  logic [2:0]       f3_valid;
  logic [2:0]       f3_ready;
  logic [2:0][5:0]  f3_id;
  logic [2:0][31:0] f3_raw;
  logic [2:0][63:0] f3_pc;
  logic [2:0][1:0]  f3_fuc;
  logic [2:0][2:0]  f3_sv, f3_sr, f3_dv;
  logic [2:0][2:0][5:0] f3_sp, f3_dp;
  logic [2:0][2:0]  wb3_en, wk3_en;
  logic [2:0][2:0][5:0] wb3_prn, wk3_prn;
  logic [2:0][1:0]  occ3;
  logic             err3;

  int total = 0;
  int bad   = 0;

  dispatch_router u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_inst_id(in_inst_id), .in_raw_instr(in_raw_instr),
    .in_pc(in_pc), .in_fu_choice(in_fu_choice),
    .in_src_valid(in_src_valid), .in_src_ready(in_src_ready),
    .in_src_prn(in_src_prn), .in_dst_valid(in_dst_valid),
    .in_dst_prn(in_dst_prn),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_inst_id(fu_inst_id), .fu_raw_instr(fu_raw_instr),
    .fu_pc(fu_pc), .fu_fu_choice(fu_fu_choice),
    .fu_src_valid(fu_src_valid), .fu_src_ready(fu_src_ready),
    .fu_src_prn(fu_src_prn), .fu_dst_valid(fu_dst_valid),
    .fu_dst_prn(fu_dst_prn),
    .wb_en(wb_en), .wb_prn(wb_prn),
    .wake_en(wake_en), .wake_prn(wake_prn),
    .fu_occupancy(fu_occupancy), .err_bad_fu(err_bad_fu)
  );

  dispatch_router #(.FU_COUNT(3)) u_dut3 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .in_inst_id(in_inst_id), .in_raw_instr(in_raw_instr),
    .in_pc(in_pc), .in_fu_choice(in_fu_choice),
    .in_src_valid(in_src_valid), .in_src_ready(in_src_ready),
    .in_src_prn(in_src_prn), .in_dst_valid(in_dst_valid),
    .in_dst_prn(in_dst_prn),
    .fu_valid(f3_valid), .fu_ready(f3_ready),
    .fu_inst_id(f3_id), .fu_raw_instr(f3_raw),
    .fu_pc(f3_pc), .fu_fu_choice(f3_fuc),
    .fu_src_valid(f3_sv), .fu_src_ready(f3_sr),
    .fu_src_prn(f3_sp), .fu_dst_valid(f3_dv),
    .fu_dst_prn(f3_dp),
    .wb_en(wb3_en), .wb_prn(wb3_prn),
    .wake_en(wk3_en), .wake_prn(wk3_prn),
    .fu_occupancy(occ3), .err_bad_fu(err3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid     = 1'b0;
    in_valid3    = 1'b0;
    in_inst_id   = '0;
    in_raw_instr = '0;
    in_pc        = '0;
    in_fu_choice = '0;
    in_src_valid = '0;
    in_src_ready = '0;
    in_src_prn   = '0;
    in_dst_valid = '0;
    in_dst_prn   = '0;
    wb_en        = '0;
    wb_prn       = '0;
  endtask

  task automatic send(input logic [5:0] id, input logic [1:0] fu);
    in_valid     = 1'b1;
    in_inst_id   = id;
    in_raw_instr = {26'h0, id};
    in_fu_choice = fu;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    fu_ready = '0;
    f3_ready = '0;
    wb3_en   = '0;
    wb3_prn  = '0;
    wb_en    = '1;
    wb_prn   = '1;
    tick();
    tick();
    total++;
    if (wake_en !== '0) begin
      bad++; $display("FAIL rst_wake_en got=%0h exp=0", wake_en);
    end
    total++;
    if (wake_prn !== '0) begin
      bad++; $display("FAIL rst_wake_prn got=%0h exp=0", wake_prn);
    end
    idle();
    #1;
    total++;
    if (fu_valid !== '0 || fu_occupancy !== '0 || err_bad_fu !== 1'b0) begin
      bad++; $display("FAIL rst_state got=%0h/%0h/%0b exp=0",
                      fu_valid, fu_occupancy, err_bad_fu);
    end
    total++;
    if (fu_inst_id !== '0 || fu_pc !== '0 || fu_src_prn !== '0) begin
      bad++; $display("FAIL rst_payload got=%0h exp=0", fu_inst_id);
    end
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    fu_ready = 4'b0100;
    send(6'd5, 2'd2);
    #1;
    total++;
    if (in_ready !== 1'b1 || fu_valid !== 4'b0) begin
      bad++; $display("FAIL basic_pre got=%0b/%0h exp=1/0",
                      in_ready, fu_valid);
    end
    tick();
    idle();
    #1;
    total++;
    if (fu_valid !== 4'b0100 || fu_inst_id[2] !== 6'd5) begin
      bad++; $display("FAIL basic_lat got=%0h/%0d exp=4/5",
                      fu_valid, fu_inst_id[2]);
    end
    total++;
    if (fu_occupancy[2] !== 2'd1) begin
      bad++; $display("FAIL basic_occ got=%0d exp=1", fu_occupancy[2]);
    end
    tick();
    total++;
    if (fu_occupancy[2] !== 2'd0 || fu_valid !== 4'b0) begin
      bad++; $display("FAIL basic_pop got=%0d exp=0", fu_occupancy[2]);
    end
    fu_ready = '0;
  endtask

  task automatic test_backpressure();
    fu_ready = '0;
    send(6'd10, 2'd1);
    tick();
    send(6'd11, 2'd1);
    tick();
    send(6'd12, 2'd1);
    #1;
    total++;
    if (in_ready !== 1'b0 || fu_occupancy[1] !== 2'd2) begin
      bad++; $display("FAIL bp_full got=%0b/%0d exp=0/2",
                      in_ready, fu_occupancy[1]);
    end
    tick();
    fu_ready = 4'b0010;
    #1;
    total++;
    if (in_ready !== 1'b0 || fu_inst_id[1] !== 6'd10) begin
      bad++; $display("FAIL bp_full_pop got=%0b/%0d exp=0/10",
                      in_ready, fu_inst_id[1]);
    end
    tick();
    total++;
    if (in_ready !== 1'b1 || fu_inst_id[1] !== 6'd11) begin
      bad++; $display("FAIL bp_accept got=%0b/%0d exp=1/11",
                      in_ready, fu_inst_id[1]);
    end
    tick();
    idle();
    #1;
    total++;
    if (fu_inst_id[1] !== 6'd12 || fu_occupancy[1] !== 2'd1) begin
      bad++; $display("FAIL bp_third got=%0d/%0d exp=12/1",
                      fu_inst_id[1], fu_occupancy[1]);
    end
    tick();
    total++;
    if (fu_occupancy[1] !== 2'd0) begin
      bad++; $display("FAIL bp_drain got=%0d exp=0", fu_occupancy[1]);
    end
    fu_ready = '0;
  endtask

  task automatic test_wakeup();
    fu_ready = '0;
    send(6'd20, 2'd0);
    in_src_valid  = 3'b001;
    in_src_prn[0] = 6'd17;
    tick();
    idle();
    #1;
    total++;
    if (fu_src_ready[0] !== 3'b000) begin
      bad++; $display("FAIL wk_before got=%0b exp=0", fu_src_ready[0]);
    end
    wb_en[3][0]  = 1'b1;
    wb_prn[3][0] = 6'd17;
    #1;
    total++;
    if (fu_src_ready[0] !== 3'b001) begin
      bad++; $display("FAIL wk_comb got=%0b exp=1", fu_src_ready[0]);
    end
    tick();
    idle();
    #1;
    total++;
    if (wake_en[3][0] !== 1'b1 || wake_prn[3][0] !== 6'd17) begin
      bad++; $display("FAIL wk_bcast got=%0b/%0d exp=1/17",
                      wake_en[3][0], wake_prn[3][0]);
    end
    fu_ready = 4'b0001;
    #1;
    total++;
    if (fu_src_ready[0] !== 3'b001 || fu_inst_id[0] !== 6'd20) begin
      bad++; $display("FAIL wk_sticky got=%0b/%0d exp=1/20",
                      fu_src_ready[0], fu_inst_id[0]);
    end
    tick();
    total++;
    if (wake_en !== '0 || fu_occupancy[0] !== 2'd0) begin
      bad++; $display("FAIL wk_after got=%0h/%0d exp=0/0",
                      wake_en, fu_occupancy[0]);
    end
    fu_ready = '0;
  endtask

  task automatic test_same_cycle();
    fu_ready = '0;
    send(6'd30, 2'd3);
    in_src_valid  = 3'b001;
    in_src_prn[0] = 6'd9;
    in_src_prn[1] = 6'd9;
    wb_en[0][1]   = 1'b1;
    wb_prn[0][1]  = 6'd9;
    tick();
    idle();
    #1;
    total++;
    if (fu_src_ready[3] !== 3'b001 || fu_valid[3] !== 1'b1) begin
      bad++; $display("FAIL sc_enq got=%0b/%0b exp=001/1",
                      fu_src_ready[3], fu_valid[3]);
    end
    fu_ready = 4'b1000;
    tick();
    fu_ready = '0;
    send(6'd31, 2'd3);
    in_src_valid  = 3'b001;
    in_src_prn[0] = 6'd9;
    in_src_prn[1] = 6'd9;
    tick();
    idle();
    #1;
    total++;
    if (fu_src_ready[3] !== 3'b000) begin
      bad++; $display("FAIL sc_nowb got=%0b exp=0", fu_src_ready[3]);
    end
    wb_en[2][2]  = 1'b1;
    wb_prn[2][2] = 6'd9;
    fu_ready     = 4'b1000;
    #1;
    total++;
    if (fu_src_ready[3] !== 3'b001 || fu_inst_id[3] !== 6'd31) begin
      bad++; $display("FAIL sc_pop got=%0b/%0d exp=001/31",
                      fu_src_ready[3], fu_inst_id[3]);
    end
    tick();
    idle();
    #1;
    total++;
    if (fu_occupancy[3] !== 2'd0) begin
      bad++; $display("FAIL sc_drain got=%0d exp=0", fu_occupancy[3]);
    end
    fu_ready = '0;
  endtask

  task automatic test_bad_fu();
    idle();
    in_valid3    = 1'b1;
    in_fu_choice = 2'd3;
    in_inst_id   = 6'd33;
    #1;
    total++;
    if (in_ready3 !== 1'b1 || err3 !== 1'b0) begin
      bad++; $display("FAIL bad_rdy got=%0b/%0b exp=1/0", in_ready3, err3);
    end
    tick();
    in_valid3 = 1'b0;
    #1;
    total++;
    if (err3 !== 1'b1 || f3_valid !== 3'b0 || occ3 !== '0) begin
      bad++; $display("FAIL bad_err got=%0b/%0h exp=1/0", err3, f3_valid);
    end
    tick();
    total++;
    if (err3 !== 1'b0 || f3_valid !== 3'b0) begin
      bad++; $display("FAIL bad_pulse got=%0b/%0h exp=0/0", err3, f3_valid);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    fu_ready = '0;
    for (int k = 0; k < 8; k++) begin
      send(6'(40 + k), 2'(k % 4));
      tick();
    end
    idle();
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (fu_occupancy[i] !== 2'd2) begin
        bad++; $display("FAIL rm_fill%0d got=%0d exp=2", i, fu_occupancy[i]);
      end
    end
    rst = 1'b0;
    #1;
    total++;
    if (fu_occupancy !== '0 || fu_valid !== '0) begin
      bad++; $display("FAIL rm_async got=%0h/%0h exp=0",
                      fu_occupancy, fu_valid);
    end
    tick();
    rst      = 1'b1;
    fu_ready = 4'hf;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (fu_valid !== '0 || fu_inst_id !== '0) begin
        bad++; $display("FAIL rm_stale got=%0h exp=0", fu_valid);
      end
    end
    fu_ready = '0;
  endtask

  typedef struct {
    logic [5:0]      id;
    logic [31:0]     raw;
    logic [2:0]      sv;
    logic [2:0]      sr;
    logic [2:0][5:0] sp;
  } ment_t;

  ment_t mq [4][$];

  // Ready bits a writeback set would grant to these operands.
  function automatic logic [2:0] woken(input logic [2:0] sv,
                                       input logic [2:0][5:0] sp);
    logic [63:0] hit;
    logic [2:0]  r;
    hit = '0;
    for (int f = 0; f < 4; f++)
      for (int k = 0; k < 3; k++)
        if (wb_en[f][k]) hit[wb_prn[f][k]] = 1'b1;
    for (int j = 0; j < 3; j++) r[j] = sv[j] & hit[sp[j]];
    return r;
  endfunction

  task automatic test_random();
    logic [3:0][2:0]      p_en;
    logic [3:0][2:0][5:0] p_prn;
    logic                 exp_rdy;
    ment_t                e;
    p_en  = '0;
    p_prn = '0;
    for (int c = 0; c < 400; c++) begin
      idle();
      in_valid     = ($urandom_range(0, 9) < 7);
      in_fu_choice = 2'($urandom_range(0, 3));
      in_inst_id   = 6'($urandom);
      in_raw_instr = $urandom;
      in_pc        = {$urandom, $urandom};
      in_src_valid = 3'($urandom);
      in_src_ready = 3'($urandom) & 3'($urandom);
      in_dst_valid = 3'($urandom);
      for (int j = 0; j < 3; j++) begin
        in_src_prn[j] = 6'($urandom_range(0, 7));
        in_dst_prn[j] = 6'($urandom);
      end
      fu_ready = 4'($urandom);
      for (int f = 0; f < 4; f++)
        for (int k = 0; k < 3; k++) begin
          wb_en[f][k]  = ($urandom_range(0, 11) == 0);
          wb_prn[f][k] = 6'($urandom_range(0, 7));
        end
      #1;
      exp_rdy = (mq[in_fu_choice].size() < 2);
      total++;
      if (in_ready !== exp_rdy) begin
        bad++; $display("FAIL rnd_rdy c=%0d got=%0b exp=%0b",
                        c, in_ready, exp_rdy);
      end
      for (int i = 0; i < 4; i++) begin
        total++;
        if (fu_occupancy[i] !== 2'(mq[i].size())
            || fu_valid[i] !== (mq[i].size() != 0)) begin
          bad++; $display("FAIL rnd_occ c=%0d fu=%0d got=%0d exp=%0d",
                          c, i, fu_occupancy[i], mq[i].size());
        end
        if (mq[i].size() != 0) begin
          e = mq[i][0];
          total++;
          if (fu_inst_id[i] !== e.id || fu_raw_instr[i] !== e.raw
              || fu_src_ready[i] !== (e.sr | woken(e.sv, e.sp))) begin
            bad++; $display("FAIL rnd_head c=%0d fu=%0d got=%0d/%0b exp=%0d/%0b",
                            c, i, fu_inst_id[i], fu_src_ready[i],
                            e.id, e.sr | woken(e.sv, e.sp));
          end
        end
      end
      total++;
      if (wake_en !== p_en || wake_prn !== p_prn || err_bad_fu !== 1'b0) begin
        bad++; $display("FAIL rnd_wake c=%0d got=%0h exp=%0h",
                        c, wake_en, p_en);
      end
      for (int i = 0; i < 4; i++) begin
        for (int k = 0; k < mq[i].size(); k++) begin
          e = mq[i][k];
          e.sr = e.sr | woken(e.sv, e.sp);
          mq[i][k] = e;
        end
        if (mq[i].size() != 0 && fu_ready[i])
          void'(mq[i].pop_front());
      end
      if (in_valid && exp_rdy) begin
        e.id  = in_inst_id;
        e.raw = in_raw_instr;
        e.sv  = in_src_valid;
        e.sp  = in_src_prn;
        e.sr  = in_src_ready | woken(in_src_valid, in_src_prn);
        mq[in_fu_choice].push_back(e);
      end
      p_en  = wb_en;
      p_prn = wb_prn;
      tick();
    end
    idle();
    fu_ready = '0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_wakeup();
    test_same_cycle();
    test_bad_fu();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
